// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit driving the core's DMEM port. It aligns and
//            extends load data and handles the 1-cycle synchronous read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu #(
  parameter int unsigned MEM_SIZE = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_stall,
  output logic        lsu_valid,
  output logic        lsu_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [31:0] C_MEM_LIMIT = 32'(MEM_SIZE);

  state_t      r_state;
  logic [1:0]  r_off;
  logic [2:0]  r_size;
  logic [31:0] r_rdata;

  logic        w_illegal;
  logic        w_accept;
  logic [31:0] w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_illegal = 1'b0;
    unique case (lsu_size)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = lsu_addr[0];
      3'b010:  w_illegal = (lsu_addr[1:0] != 2'b00);
      3'b100:  w_illegal = lsu_we;
      3'b101:  w_illegal = lsu_we | lsu_addr[0];
      default: w_illegal = 1'b1;
    endcase
    if (lsu_addr >= C_MEM_LIMIT) begin
      w_illegal = 1'b1;
    end
  end

  assign w_accept = !rst && (r_state == IDLE) && lsu_req;

  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = 32'h0;
    lsu_err    = 1'b0;
    lsu_stall  = 1'b0;
    dmem_addr  = {lsu_addr[31:2], 2'b00};
    if (w_accept) begin
      if (w_illegal) begin
        lsu_err = 1'b1;
      end else if (lsu_we) begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        unique case (lsu_size[1:0])
          2'b00: begin
            dmem_be    = 4'b0001 << lsu_addr[1:0];
            dmem_wdata = {4{lsu_wdata[7:0]}};
          end
          2'b01: begin
            dmem_be    = 4'b0011 << lsu_addr[1:0];
            dmem_wdata = {2{lsu_wdata[15:0]}};
          end
          default: begin
            dmem_be    = 4'b1111;
            dmem_wdata = lsu_wdata;
          end
        endcase
      end else begin
        dmem_req  = 1'b1;
        dmem_be   = 4'b1111;
        lsu_stall = 1'b1;
      end
    end
  end

  // Lane selection uses the offset/size captured when the load issued.
  always_comb begin
    w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (r_size[1:0])
      2'b00:   w_ext = {{24{w_byte[7] & ~r_size[2]}}, w_byte};
      2'b01:   w_ext = {{16{w_half[15] & ~r_size[2]}}, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  assign lsu_valid = !rst && (r_state == RESP);
  assign lsu_rdata = lsu_valid ? w_ext : r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdata <= 32'h0;
      r_off   <= 2'b00;
      r_size  <= 3'b000;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (lsu_stall) begin
            r_off   <= lsu_addr[1:0];
            r_size  <= lsu_size;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_rdata <= w_ext;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
